// File: rtl/plab4_net_router_output_ctrl_pkg.sv
// Shared types and constants for the router output-port controller:
// FSM encoding, input-port indices and the reset priority pointer.
package plab4_net_router_output_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int         NUM_REQS  = 3;
    localparam logic [1:0] PORT_0    = 2'd0;
    localparam logic [1:0] PORT_1    = 2'd1;
    localparam logic [1:0] PORT_2    = 2'd2;
    localparam logic [2:0] INIT_PRIO = 3'b001;

    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // Successor port index, wrapping from the last port back to the first.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == PORT_2) ? PORT_0 : idx + PORT_1;
    endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_rr_pick.sv
// Combinational round-robin picker: first requesting port at or after the
// one-hot priority pointer, wrapping from port 2 back to port 0.
module plab4_net_RoundRobinPick
    import plab4_net_router_output_ctrl_pkg::*;
(
    input  logic [2:0] reqs,
    input  logic [2:0] prio,
    output logic [2:0] grant,
    output logic [1:0] idx
);

    logic [1:0] base;
    logic [2:0] pos;
    logic       found;

    always_comb begin
        base  = PORT_0;
        pos   = 3'd0;
        found = 1'b0;
        grant = 3'b000;
        idx   = PORT_0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (prio[i]) base = 2'(i);
        end
        for (int k = 0; k < NUM_REQS; k++) begin
            pos = {1'b0, base} + 3'(k);
            if (pos >= 3'd3) pos = pos - 3'd3;
            if (!found && reqs[pos[1:0]]) begin
                found = 1'b1;
                idx   = pos[1:0];
                grant = idx_to_onehot(pos[1:0]);
            end
        end
    end

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// Output-port controller of a mesh router: round-robin arbitration among the
// input ports, with the winner locked while downstream is not ready.
module plab4_net_router_output_ctrl
    import plab4_net_router_output_ctrl_pkg::*;
#(
    parameter int         p_num_reqs  = NUM_REQS,
    parameter logic [2:0] p_init_prio = INIT_PRIO
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [p_num_reqs-1:0] reqs,
    output logic [p_num_reqs-1:0] grants,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [1:0]            sel
);

    state_t     state;
    state_t     state_next;
    logic [2:0] prio;
    logic [1:0] hold_idx;
    logic [2:0] stall_cnt;

    logic [2:0] rr_grant;
    logic [1:0] rr_idx;
    logic       hold_active;
    logic [1:0] win_idx;
    logic       xfer;

    plab4_net_RoundRobinPick rr_pick (
        .reqs  (reqs),
        .prio  (prio),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // A lock only holds while its owner keeps requesting; otherwise fall back
    // to the round-robin pick in the same cycle.
    always_comb begin
        hold_active = (state == HOLD) && reqs[hold_idx];
        win_idx     = hold_active ? hold_idx : rr_idx;
        out_val     = |reqs;
        xfer        = out_val && out_rdy;
        sel         = win_idx;
        grants      = 3'b000;
        if (out_rdy) begin
            grants = hold_active ? idx_to_onehot(hold_idx) : rr_grant;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (out_val && !out_rdy)          state_next = HOLD;
            HOLD: if (xfer || !reqs[hold_idx])      state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prio      <= p_init_prio;
            hold_idx  <= PORT_0;
            stall_cnt <= 3'd0;
        end else begin
            state <= state_next;
            if (xfer) prio <= idx_to_onehot(next_idx(win_idx));
            if (state == IDLE && state_next == HOLD) hold_idx <= rr_idx;
            // Debug-only count of stalled cycles spent holding a lock.
            if (state == HOLD && state_next == HOLD) begin
                if (stall_cnt != 3'd7) stall_cnt <= stall_cnt + 3'd1;
            end else begin
                stall_cnt <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// Self-checking bench for the router output-port controller: a behavioural
// arbiter model feeds a queue of expected outputs, popped as the DUT responds.
`timescale 1ns/1ps
module tb_plab4_net_router_output_ctrl;

    logic       clk;
    logic       reset_n;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic       out_val;
    logic       out_rdy;
    logic [1:0] sel;

    plab4_net_router_output_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .reqs    (reqs),
        .grants  (grants),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] g;
        logic [1:0] s;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state (priority kept as an index, not one-hot)
    int   m_pidx  = 0;
    logic m_state = 1'b0;
    int   m_hold  = 0;
    int   m_stall = 0;

    // Apply one cycle of stimulus, queue the expected outputs, advance the model.
    task automatic drive(input logic [2:0] r, input logic rdy);
        exp_t e;
        int   w;
        logic act, xfer, nxt;
        @(negedge clk);
        reqs    = r;
        out_rdy = rdy;
        act = m_state && r[m_hold];
        w = 0;
        if (act) w = m_hold;
        else for (int k = 2; k >= 0; k--) if (r[(m_pidx + k) % 3]) w = (m_pidx + k) % 3;
        e.v = |r;
        e.g = (rdy && |r) ? 3'(1 << w) : 3'b000;
        e.s = (|r) ? 2'(w) : 2'd0;
        sb.push_back(e);
        xfer = (|r) && rdy;
        nxt  = m_state;
        if (!m_state) begin
            if ((|r) && !rdy) begin nxt = 1'b1; m_hold = w; end
        end else if (xfer || !r[m_hold]) begin
            nxt = 1'b0;
        end
        m_stall = (m_state && nxt) ? ((m_stall == 7) ? 7 : m_stall + 1) : 0;
        if (xfer) m_pidx = (w + 1) % 3;
        m_state = nxt;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; reqs = 3'b000; out_rdy = 1'b0;
        #12;
        n_chk++; if (grants !== 3'b000) begin n_fail++; $display("FAIL reset_grants got %b want 000", grants); end
        n_chk++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val got %b want 0", out_val); end
        n_chk++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", sel); end
        n_chk++; if (logic'(dut.state) !== 1'b0) begin n_fail++; $display("FAIL reset_state got %b want 0", dut.state); end
        n_chk++; if (dut.prio !== 3'b001) begin n_fail++; $display("FAIL reset_prio got %b want 001", dut.prio); end
        // Outputs still arbitrate from reset register values, but no state moves.
        reqs = 3'b110; out_rdy = 1'b1;
        #1;
        n_chk++; if (grants !== 3'b010) begin n_fail++; $display("FAIL inreset_grants got %b want 010", grants); end
        n_chk++; if (sel !== 2'd1) begin n_fail++; $display("FAIL inreset_sel got %0d want 1", sel); end
        @(posedge clk); #1;
        n_chk++; if (dut.prio !== 3'b001) begin n_fail++; $display("FAIL inreset_prio got %b want 001", dut.prio); end
        @(negedge clk);
        reqs = 3'b000; out_rdy = 1'b0; reset_n = 1'b1;
    endtask

    task automatic test_rr_rotation();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            drive(3'b111, 1'b1);
            e = sb.pop_front();
            n_chk++; if (grants !== e.g) begin n_fail++; $display("FAIL rr_grants[%0d] got %b want %b", c, grants, e.g); end
            n_chk++; if (sel !== e.s) begin n_fail++; $display("FAIL rr_sel[%0d] got %0d want %0d", c, sel, e.s); end
            n_chk++; if (out_val !== e.v) begin n_fail++; $display("FAIL rr_out_val[%0d] got %b want %b", c, out_val, e.v); end
        end
    endtask

    task automatic test_hold();
        logic [2:0] tr[3]  = '{3'b101, 3'b101, 3'b101};
        logic       trd[3] = '{1'b0, 1'b0, 1'b1};
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            drive(tr[c], trd[c]);
            e = sb.pop_front();
            n_chk++; if (grants !== e.g) begin n_fail++; $display("FAIL hold_grants[%0d] got %b want %b", c, grants, e.g); end
            n_chk++; if (sel !== e.s) begin n_fail++; $display("FAIL hold_sel[%0d] got %0d want %0d", c, sel, e.s); end
            @(posedge clk); #1;
            n_chk++; if (logic'(dut.state) !== m_state) begin n_fail++; $display("FAIL hold_state[%0d] got %b want %b", c, dut.state, m_state); end
            n_chk++; if (dut.prio !== 3'(1 << m_pidx)) begin n_fail++; $display("FAIL hold_prio[%0d] got %b want %b", c, dut.prio, 3'(1 << m_pidx)); end
        end
    endtask

    task automatic test_withdraw();
        logic [2:0] tr[3]  = '{3'b100, 3'b101, 3'b100};
        logic       trd[3] = '{1'b1, 1'b0, 1'b1};
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            drive(tr[c], trd[c]);
            e = sb.pop_front();
            n_chk++; if (grants !== e.g) begin n_fail++; $display("FAIL wd_grants[%0d] got %b want %b", c, grants, e.g); end
            n_chk++; if (sel !== e.s) begin n_fail++; $display("FAIL wd_sel[%0d] got %0d want %0d", c, sel, e.s); end
            if (c == 2) begin
                n_chk++; if (dut.prio !== 3'b001) begin n_fail++; $display("FAIL wd_prio_before got %b want 001", dut.prio); end
            end
            @(posedge clk); #1;
            n_chk++; if (logic'(dut.state) !== m_state) begin n_fail++; $display("FAIL wd_state[%0d] got %b want %b", c, dut.state, m_state); end
            n_chk++; if (dut.prio !== 3'(1 << m_pidx)) begin n_fail++; $display("FAIL wd_prio[%0d] got %b want %b", c, dut.prio, 3'(1 << m_pidx)); end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] tr[2] = '{3'b010, 3'b011};
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            drive(tr[c], 1'b1);
            e = sb.pop_front();
            n_chk++; if (grants !== e.g) begin n_fail++; $display("FAIL wrap_grants[%0d] got %b want %b", c, grants, e.g); end
            @(posedge clk); #1;
            n_chk++; if (dut.prio !== 3'(1 << m_pidx)) begin n_fail++; $display("FAIL wrap_prio[%0d] got %b want %b", c, dut.prio, 3'(1 << m_pidx)); end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int c = 0; c < 11; c++) begin
            drive(3'b001, (c == 10));
            e = sb.pop_front();
            n_chk++; if (grants !== e.g) begin n_fail++; $display("FAIL stall_grants[%0d] got %b want %b", c, grants, e.g); end
            @(posedge clk); #1;
            if (c >= 8) begin
                n_chk++; if (dut.stall_cnt !== 3'(m_stall)) begin n_fail++; $display("FAIL stall_cnt[%0d] got %0d want %0d", c, dut.stall_cnt, m_stall); end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(3'b010, 1'b0);
        e = sb.pop_front();
        n_chk++; if (grants !== e.g) begin n_fail++; $display("FAIL ar_grants_pre got %b want %b", grants, e.g); end
        @(posedge clk); #1;
        n_chk++; if (logic'(dut.state) !== m_state) begin n_fail++; $display("FAIL ar_state_pre got %b want %b", dut.state, m_state); end
        n_chk++; if (dut.prio !== 3'(1 << m_pidx)) begin n_fail++; $display("FAIL ar_prio_pre got %b want %b", dut.prio, 3'(1 << m_pidx)); end
        #2;
        reset_n = 1'b0;
        m_state = 1'b0; m_pidx = 0; m_hold = 0; m_stall = 0;
        #1;
        n_chk++; if (logic'(dut.state) !== 1'b0) begin n_fail++; $display("FAIL ar_state got %b want 0", dut.state); end
        n_chk++; if (dut.prio !== 3'b001) begin n_fail++; $display("FAIL ar_prio got %b want 001", dut.prio); end
        n_chk++; if (sel !== 2'd1) begin n_fail++; $display("FAIL ar_sel got %0d want 1", sel); end
        @(negedge clk);
        reset_n = 1'b1;
        drive(3'b010, 1'b1);
        e = sb.pop_front();
        n_chk++; if (grants !== e.g) begin n_fail++; $display("FAIL ar_grants_post got %b want %b", grants, e.g); end
        n_chk++; if (grants !== 3'b010) begin n_fail++; $display("FAIL ar_grants_const got %b want 010", grants); end
    endtask

    task automatic test_random();
        exp_t e;
        int   waits[3] = '{0, 0, 0};
        logic [2:0] r;
        logic rdy;
        for (int c = 0; c < 10000; c++) begin
            r   = 3'($urandom_range(0, 7));
            rdy = 1'($urandom_range(0, 1));
            drive(r, rdy);
            e = sb.pop_front();
            n_chk++; if (grants !== e.g) begin n_fail++; $display("FAIL rand_grants[%0d] got %b want %b", c, grants, e.g); end
            n_chk++; if (sel !== e.s) begin n_fail++; $display("FAIL rand_sel[%0d] got %0d want %0d", c, sel, e.s); end
            n_chk++; if (out_val !== e.v) begin n_fail++; $display("FAIL rand_out_val[%0d] got %b want %b", c, out_val, e.v); end
            n_chk++; if ($countones(grants) > 1) begin n_fail++; $display("FAIL rand_onehot[%0d] got %b want one-hot or zero", c, grants); end
            for (int i = 0; i < 3; i++) begin
                if (!r[i] || grants[i]) waits[i] = 0;
                else if (out_val && out_rdy) waits[i]++;
                n_chk++; if (waits[i] > 2) begin n_fail++; $display("FAIL rand_starve[%0d] port %0d waited %0d want <=2", c, i, waits[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_rotation();
        test_hold();
        test_withdraw();
        test_wrap();
        test_stall();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/plab4_net_router_output_ctrl.md
PLAB4_NET_ROUTER_OUTPUT_CTRL -- requirements
Module: plab4_net_RouterOutputCtrl

Interface
REQ-001 The block SHALL have parameter p_num_reqs, default 3, meaning number of requesting input ports; only 3 is supported.
REQ-002 The block SHALL have parameter p_init_prio, default 3'b001, meaning one-hot highest-priority input after reset.
REQ-003 Port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 Port reqs, input, 3, meaning bit i set = input port i requests this output port this cycle.
REQ-006 Port grants, output, 3, meaning one-hot grant to input port i, or zero.
REQ-007 Port out_val, output, 1, meaning a flit is presented on the output channel.
REQ-008 Port out_rdy, input, 1, meaning downstream accepts the presented flit.
REQ-009 Port sel, output, 2, meaning datapath mux select = index of the current winner (0..2); 0 when no winner.
REQ-010 Every port SHALL carry security label {L}.

Function
REQ-011 Transfer SHALL occur in a cycle iff out_val && out_rdy; exactly one flit per transfer.
REQ-012 out_val SHALL equal |reqs, combinationally.
REQ-013 grants SHALL be one-hot winner when out_rdy=1, all-zero when out_rdy=0 or reqs=0.
REQ-014 Winner selection SHALL be round-robin: first set bit of reqs scanning from priority pointer prio upward, wrapping 2->0.
REQ-015 prio SHALL be a 3-bit one-hot register; on transfer it SHALL become one-hot of (winner+1) mod 3; otherwise unchanged.
REQ-016 FSM SHALL have states IDLE and HOLD; the locked winner SHALL be kept in a 2-bit register hold_idx.
REQ-017 IDLE->HOLD when reqs!=0 && out_rdy=0; hold_idx captures the round-robin winner.
REQ-018 In HOLD the winner SHALL be hold_idx regardless of other reqs or prio; sel SHALL equal hold_idx.
REQ-019 HOLD->IDLE on transfer, or when reqs[hold_idx] deasserts (requester withdrew).
REQ-020 Withdrawal in HOLD with other reqs still set SHALL re-arbitrate combinationally in the same cycle using prio; prio unchanged.
REQ-021 In IDLE with a transfer, FSM SHALL remain IDLE and winner is combinational (zero-latency grant).
REQ-022 Grant latency from reqs to grants SHALL be 0 cycles when out_rdy=1.
REQ-023 Simultaneous transfer and new reqs SHALL apply updated prio only from the next cycle.
REQ-024 A 3-bit saturating stall counter SHALL increment each HOLD cycle without transfer, clear on leaving HOLD; when saturated (7) it SHALL hold at 7 (debug only, not an output-affecting signal).

Reset
REQ-025 On reset_n=0, asynchronously: state=IDLE, prio=p_init_prio, hold_idx=0, stall counter=0.
REQ-026 During reset grants, out_val and sel SHALL follow REQ-012/013 from reset register values; no transfer updates state.
REQ-027 Reset mid-HOLD SHALL drop the lock immediately; first cycle after release arbitrates from p_init_prio.

Structure
REQ-028 Shared package SHALL hold state encodings (IDLE=0, HOLD=1), port-index constants and p_init_prio default.
REQ-029 One sub-module plab4_net_RoundRobinPick (combinational: reqs, prio -> one-hot winner, index) SHALL be used.
REQ-030 Sequential logic SHALL be prio, state, hold_idx and stall counter only; all else combinational.

Verification
REQ-031 After reset, reqs=111, out_rdy=1 for 3 cycles -> grants 001,010,100; sel 0,1,2.
REQ-032 reqs=101, out_rdy=0 two cycles, then 1 -> grants 000,000,001; state HOLD then IDLE; prio becomes 010.
REQ-033 HOLD on input 0, then reqs 101->100 -> same cycle sel=2, grants=100 if out_rdy=1; prio stays 001 until that transfer.
REQ-034 prio=100, reqs=011, out_rdy=1 -> grant 001 (wrap), next prio 010.
REQ-035 reset_n low during HOLD with reqs=010, out_rdy=0 -> state IDLE, prio 001 asynchronously; after release with out_rdy=1 grant 010.
REQ-036 Random reqs/out_rdy 10k cycles -> grants always one-hot or zero, no input starves beyond 2 competing transfers.
